// File: rtl/iq_demod_pkg.sv
// -----------------------------------------------------------------------------
// iq_demod_pkg
//   Shared definitions for the IQ demodulator blocks:
//     - sched_state_t : FIR scheduler FSM states
//     - NTAPS_DEFAULT : default FIR length (power of two, 2..64)
//     - addr_w()      : address width needed to index an NTAPS-deep delay line
// -----------------------------------------------------------------------------
package iq_demod_pkg;

  localparam int NTAPS_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    MAC_I  = 3'd2,
    DUMP_I = 3'd3,
    MAC_Q  = 3'd4,
    DUMP_Q = 3'd5,
    DONE   = 3'd6
  } sched_state_t;

  // NTAPS is a power of two >= 2, so $clog2 gives an exact, natural-wrap width.
  function automatic int addr_w(input int ntaps);
    return $clog2(ntaps);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
//   Registers a clk-synchronous level and flags its 0->1 transition. A level
//   held high yields a single-cycle rise.
//   Ports:
//     clk    in  system clock
//     resetn in  asynchronous active-low reset
//     level  in  strobe level, synchronous to clk
//     rise   out level & ~level_q (combinational, one cycle wide)
// -----------------------------------------------------------------------------
module rise_detect (
  input  logic clk,
  input  logic resetn,
  input  logic level,
  output logic rise
);

  logic level_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) level_q <= 1'b0;
    else         level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/iq_fir_scheduler.sv
// -----------------------------------------------------------------------------
// iq_fir_scheduler
//   Time-shares one MAC FIR engine between the I and Q channels. Each ADC
//   strobe runs: delay-line write, NTAPS I MACs, I dump, NTAPS Q MACs, Q dump,
//   then a one-cycle demod_rdy. One strobe arriving mid-schedule is held as
//   pending; a second one is dropped and flagged in the sticky overrun bit.
//   Ports:
//     clk, resetn  clock / asynchronous active-low reset
//     ADC_rdy      ADC sample-ready level (rising edge starts a schedule)
//     ovr_clr      clears sticky overrun (a coincident new overrun wins)
//     wr_en        write new I/Q sample into both delay lines at wr_addr
//     wr_addr      delay-line write address
//     tap_addr     delay-line read address  = (base - k) mod NTAPS
//     coef_addr    coefficient ROM address  = k
//     sel_q        0 = I channel on the MAC, 1 = Q channel
//     mac_en       MAC operates this cycle
//     mac_clr      with mac_en: load product instead of accumulating
//     i_vld/q_vld  I / Q accumulator result valid pulses
//     demod_rdy    I/Q pair complete pulse
//     busy         scheduler not idle
//     overrun      sticky, a strobe was lost
//   All outputs decode registered state only; ADC_rdy reaches no output
//   combinationally.
// -----------------------------------------------------------------------------
module iq_fir_scheduler
  import iq_demod_pkg::*;
#(
  parameter  int NTAPS  = NTAPS_DEFAULT,
  localparam int ADDR_W = addr_w(NTAPS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ADC_rdy,
  input  logic              ovr_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] tap_addr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              sel_q,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              i_vld,
  output logic              q_vld,
  output logic              demod_rdy,
  output logic              busy,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(NTAPS - 1);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  sched_state_t      state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] k;
  logic              pending;
  logic              rise;
  logic              absorb;
  logic              ovr_set;

  rise_detect u_rise_detect (
    .clk    (clk),
    .resetn (resetn),
    .level  (ADC_rdy),
    .rise   (rise)
  );

  // A strobe landing while a schedule is in flight is buffered once; IDLE and
  // DONE start the schedule directly instead.
  assign absorb  = rise && (state != IDLE) && (state != DONE);
  assign ovr_set = absorb && pending;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      base    <= '0;
      k       <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: if (rise) state <= LOAD;
        LOAD: begin
          base   <= wr_ptr;
          wr_ptr <= wr_ptr + ONE;
          k      <= '0;
          state  <= MAC_I;
        end
        MAC_I: begin
          if (k == K_LAST) begin
            k     <= '0;
            state <= DUMP_I;
          end else begin
            k <= k + ONE;
          end
        end
        DUMP_I: state <= MAC_Q;
        MAC_Q: begin
          if (k == K_LAST) begin
            k     <= '0;
            state <= DUMP_Q;
          end else begin
            k <= k + ONE;
          end
        end
        DUMP_Q: state <= DONE;
        DONE:   state <= (pending || rise) ? LOAD : IDLE;
        default: state <= IDLE;
      endcase

      // In DONE a buffered strobe is consumed first; a strobe arriving in the
      // same cycle then takes its place in the buffer rather than being lost.
      if (state == DONE)        pending <= pending & rise;
      else if (absorb && !pending) pending <= 1'b1;

      overrun <= ovr_set | (overrun & ~ovr_clr);
    end
  end

  // NOTE: every combinationally assigned signal gets a default at the top of
  // the block so no path through the case leaves it unassigned (no latches).
  always_comb begin
    wr_en     = 1'b0;
    wr_addr   = '0;
    tap_addr  = '0;
    coef_addr = '0;
    sel_q     = 1'b0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    i_vld     = 1'b0;
    q_vld     = 1'b0;
    demod_rdy = 1'b0;
    busy      = (state != IDLE);
    case (state)
      LOAD: begin
        wr_en   = 1'b1;
        wr_addr = wr_ptr;
      end
      MAC_I, MAC_Q: begin
        sel_q     = (state == MAC_Q);
        mac_en    = 1'b1;
        mac_clr   = (k == '0);
        coef_addr = k;
        tap_addr  = base - k;     // newest sample pairs with coefficient 0
      end
      DUMP_I: i_vld = 1'b1;
      DUMP_Q: begin
        q_vld = 1'b1;
        sel_q = 1'b1;
      end
      DONE:    demod_rdy = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iq_fir_scheduler.sv
// -----------------------------------------------------------------------------
// tb_iq_fir_scheduler
//   Self-checking bench for iq_fir_scheduler (NTAPS = 8). The reference model
//   tracks each schedule as a position (phase) within its 2*NTAPS+4-cycle
//   timeline plus a one-deep pending flag; expected outputs are derived from
//   the phase. Observation j after a tick with a rise corresponds to cycle
//   t+1+j of the timeline.
// -----------------------------------------------------------------------------
module tb_iq_fir_scheduler;
  import iq_demod_pkg::*;

  localparam int N  = 8;
  localparam int AW = addr_w(N);
  localparam int VW = 3 * AW + 9;
  localparam int LAST_PHASE = 2 * N + 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          adc_rdy = 1'b0;
  logic          ovr_clr = 1'b0;
  logic          wr_en, sel_q, mac_en, mac_clr, i_vld, q_vld, demod_rdy, busy, overrun;
  logic [AW-1:0] wr_addr, tap_addr, coef_addr;

  int total = 0;
  int bad   = 0;

  // reference model
  bit m_active, m_pending, m_ovr, m_adc_prev;
  int m_phase, m_base, m_wr_ptr;

  iq_fir_scheduler #(.NTAPS(N)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ADC_rdy   (adc_rdy),
    .ovr_clr   (ovr_clr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .tap_addr  (tap_addr),
    .coef_addr (coef_addr),
    .sel_q     (sel_q),
    .mac_en    (mac_en),
    .mac_clr   (mac_clr),
    .i_vld     (i_vld),
    .q_vld     (q_vld),
    .demod_rdy (demod_rdy),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] dut_vec();
    return {wr_en, wr_addr, tap_addr, coef_addr, sel_q, mac_en, mac_clr,
            i_vld, q_vld, demod_rdy, busy, overrun};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic          e_wr, e_sel, e_mac, e_clr, e_i, e_q, e_d, e_busy;
    logic [AW-1:0] e_wa, e_tap, e_coef;
    int            kk;
    {e_wr, e_sel, e_mac, e_clr, e_i, e_q, e_d, e_busy} = '0;
    e_wa = '0; e_tap = '0; e_coef = '0;
    if (m_active) begin
      e_busy = 1'b1;
      if (m_phase == 0) begin
        e_wr = 1'b1;
        e_wa = AW'(m_base);
      end else if (m_phase <= 2 * N + 1 && m_phase != N + 1) begin
        kk     = (m_phase <= N) ? m_phase - 1 : m_phase - N - 2;
        e_sel  = (m_phase > N);
        e_mac  = 1'b1;
        e_clr  = (kk == 0);
        e_coef = AW'(kk);
        e_tap  = AW'((m_base - kk + N) % N);
      end else if (m_phase == N + 1) begin
        e_i = 1'b1;
      end else if (m_phase == 2 * N + 2) begin
        e_q   = 1'b1;
        e_sel = 1'b1;
      end else begin
        e_d = 1'b1;
      end
    end
    return {e_wr, e_wa, e_tap, e_coef, e_sel, e_mac, e_clr, e_i, e_q, e_d, e_busy, m_ovr};
  endfunction

  task automatic model_reset();
    m_active = 0; m_pending = 0; m_ovr = 0; m_adc_prev = 0;
    m_phase = 0; m_base = 0; m_wr_ptr = 0;
  endtask

  task automatic model_start();
    m_active = 1;
    m_phase  = 0;
    m_base   = m_wr_ptr;
    m_wr_ptr = (m_wr_ptr + 1) % N;
  endtask

  task automatic model_step(input bit adc, input bit clr);
    bit rise, set;
    rise = adc && !m_adc_prev;
    m_adc_prev = adc;
    set = 0;
    if (m_active && m_phase == LAST_PHASE) begin
      if (m_pending) begin
        model_start();
        m_pending = rise;
      end else if (rise) begin
        model_start();
      end else begin
        m_active = 0;
      end
    end else if (m_active) begin
      m_phase++;
      if (rise) begin
        if (!m_pending) m_pending = 1;
        else            set = 1;
      end
    end else if (rise) begin
      model_start();
    end
    if (set)      m_ovr = 1;
    else if (clr) m_ovr = 0;
  endtask

  // drive one cycle of inputs, advance the model, sample just after the edge
  task automatic tick(input bit adc, input bit clr);
    adc_rdy = adc;
    ovr_clr = clr;
    model_step(adc, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn  = 1'b0;
    adc_rdy = 1'b0;
    ovr_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick(0, 0);
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    adc_rdy = 1'b0;
    ovr_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dut_vec() !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", dut_vec());
    end
    @(negedge clk);
    resetn = 1'b1;
    tick(0, 0);
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    int i_at = -1, q_at = -1, d_at = -1, nd = 0;
    do_reset();
    for (int j = 0; j < 23; j++) begin
      tick(j == 0, 0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL single j=%0d got=%h exp=%h", j, dut_vec(), exp_vec());
      end
      if (i_vld) i_at = j;
      if (q_vld) q_at = j;
      if (demod_rdy) begin d_at = j; nd++; end
      if (j == 0) begin
        total++;
        if (wr_en !== 1'b1 || wr_addr !== '0) begin
          bad++;
          $display("FAIL single_load wr_en=%b wr_addr=%0d exp 1/0", wr_en, wr_addr);
        end
      end
      if (j == 20) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL single_busy_t21 got=%b exp=0", busy);
        end
      end
    end
    total++;
    if (i_at != 9 || q_at != 18 || d_at != 19 || nd != 1) begin
      bad++;
      $display("FAIL single_latency i=%0d q=%0d d=%0d n=%0d exp 9/18/19/1", i_at, q_at, d_at, nd);
    end
  endtask

  task automatic test_held_level();
    int nd = 0;
    do_reset();
    for (int j = 0; j < 75; j++) begin
      tick(j < 50, 0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL held j=%0d got=%h exp=%h", j, dut_vec(), exp_vec());
      end
      if (demod_rdy) nd++;
    end
    total++;
    if (nd != 1 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL held_level demods=%0d ovr=%b exp 1/0", nd, overrun);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int s = 0; s < 9; s++) begin
      for (int j = 0; j < 20; j++) begin
        tick(j == 0, 0);
        total++;
        if (dut_vec() !== exp_vec()) begin
          bad++;
          $display("FAIL wrap s=%0d j=%0d got=%h exp=%h", s, j, dut_vec(), exp_vec());
        end
        if (j == 0) begin
          total++;
          if (wr_en !== 1'b1 || wr_addr !== AW'(s % N)) begin
            bad++;
            $display("FAIL wrap_wr_addr s=%0d got=%0d exp=%0d", s, wr_addr, s % N);
          end
        end
        if (s == 8 && (j == 1 || j == 2)) begin
          total++;
          if (tap_addr !== ((j == 1) ? AW'(0) : AW'(7))) begin
            bad++;
            $display("FAIL wrap_tap j=%0d got=%0d exp=%0d", j, tap_addr, (j == 1) ? 0 : 7);
          end
        end
      end
    end
    repeat (3) tick(0, 0);
    total++;
    if (overrun !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL wrap_end ovr=%b busy=%b exp 0/0", overrun, busy);
    end
  endtask

  task automatic test_pending();
    int d_first = -1, d_second = -1, load2 = -1;
    do_reset();
    for (int j = 0; j < 45; j++) begin
      tick(j == 0 || j == 5, 0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL pending j=%0d got=%h exp=%h", j, dut_vec(), exp_vec());
      end
      if (demod_rdy) begin
        if (d_first < 0) d_first = j;
        else             d_second = j;
      end
      if (wr_en && j > 0) load2 = j;
    end
    total++;
    if (d_first != 19 || load2 != 20 || d_second != 39) begin
      bad++;
      $display("FAIL pending_timing d1=%0d load2=%0d d2=%0d exp 19/20/39", d_first, load2, d_second);
    end
  endtask

  task automatic test_overrun();
    int nd = 0;
    do_reset();
    for (int j = 0; j < 60; j++) begin
      tick(j == 0 || j == 5 || j == 8, 0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL overrun j=%0d got=%h exp=%h", j, dut_vec(), exp_vec());
      end
      if (j == 7 || j == 8) begin
        total++;
        if (overrun !== (j == 8)) begin
          bad++;
          $display("FAIL overrun_flag j=%0d got=%b exp=%b", j, overrun, j == 8);
        end
      end
      if (demod_rdy) nd++;
    end
    total++;
    if (nd != 2) begin
      bad++;
      $display("FAIL overrun_demods got=%0d exp=2", nd);
    end
    tick(0, 1);
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clear got=%b exp=0", overrun);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int j = 0; j < 12; j++) begin
      tick(j == 0, 0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL rmid_pre j=%0d got=%h exp=%h", j, dut_vec(), exp_vec());
      end
    end
    resetn  = 1'b0;
    adc_rdy = 1'b0;
    model_reset();
    #1;
    total++;
    if (dut_vec() !== '0) begin
      bad++;
      $display("FAIL rmid_async got=%h exp=0", dut_vec());
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick(0, 0);
      total++;
      if (dut_vec() !== '0) begin
        bad++;
        $display("FAIL rmid_quiet j=%0d got=%h exp=0", j, dut_vec());
      end
    end
    for (int j = 0; j < 22; j++) begin
      tick(j == 0, 0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL rmid_post j=%0d got=%h exp=%h", j, dut_vec(), exp_vec());
      end
      if (j == 0) begin
        total++;
        if (wr_en !== 1'b1 || wr_addr !== '0) begin
          bad++;
          $display("FAIL rmid_wr_addr wr_en=%b got=%0d exp 1/0", wr_en, wr_addr);
        end
      end
    end
  endtask

  task automatic test_random();
    bit adc = 0;
    for (int j = 0; j < 800; j++) begin
      if ($urandom_range(0, 5) == 0) adc = ~adc;
      tick(adc, $urandom_range(0, 29) == 0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random j=%0d got=%h exp=%h", j, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_held_level();
    test_wrap();
    test_pending();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iq_fir_scheduler.md
Name: iq_fir_scheduler

Overview:
- Sequences one shared multiply-accumulate FIR engine across the I and Q channels of the IQ demodulator.
- Each ADC sample strobe triggers, in order:
  - a delay-line write;
  - NTAPS MAC cycles for I, then an I result strobe;
  - NTAPS MAC cycles for Q, then a Q result strobe;
  - a one-cycle demod_rdy pulse to downstream demod logic.
- Buffers one pending strobe and flags overrun when strobes arrive faster than the schedule can absorb.

Parameters:
- NTAPS, 8, filter length. Power of two, 2..64. Local ADDR_W = clog2(NTAPS).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- ADC_rdy  in  1  ADC sample-ready level, synchronous to clk; only the rising edge is used
- ovr_clr  in  1  clears sticky overrun
- wr_en  out  1  write new I and Q samples into both delay lines
- wr_addr  out  ADDR_W  delay-line write address
- tap_addr  out  ADDR_W  delay-line read address
- coef_addr  out  ADDR_W  coefficient ROM address
- sel_q  out  1  0 = I channel on MAC, 1 = Q channel
- mac_en  out  1  MAC performs an operation this cycle
- mac_clr  out  1  with mac_en: load product instead of accumulate
- i_vld  out  1  I accumulator result valid (1-cycle pulse)
- q_vld  out  1  Q accumulator result valid (1-cycle pulse)
- demod_rdy  out  1  I/Q pair complete (1-cycle pulse)
- busy  out  1  state != IDLE
- overrun  out  1  sticky, strobe lost

Behaviour:
- Reset:
  - state IDLE; wr_ptr, tap counter k, pending, overrun and the previous ADC_rdy register all 0.
  - All outputs 0.
  - Delay-line and ROM contents are not touched.
- Edge detect: rise = ADC_rdy & ~ADC_rdy_q, where ADC_rdy_q is ADC_rdy registered every cycle. A level held high produces one rise only.
- FSM states: IDLE, LOAD, MAC_I, DUMP_I, MAC_Q, DUMP_Q, DONE.
  - IDLE: rise -> LOAD, otherwise stay.
  - LOAD: wr_en=1, wr_addr=wr_ptr. Latch base=wr_ptr; wr_ptr <= wr_ptr+1 (wraps mod NTAPS). k<=0. -> MAC_I.
  - MAC_I: mac_en=1, sel_q=0, mac_clr=(k==0), coef_addr=k, tap_addr=(base-k) mod NTAPS. k++. When k==NTAPS-1 -> DUMP_I with k<=0.
  - DUMP_I: i_vld=1, sel_q=0. -> MAC_Q.
  - MAC_Q: same as MAC_I with sel_q=1. Last tap -> DUMP_Q.
  - DUMP_Q: q_vld=1, sel_q=1. -> DONE.
  - DONE: demod_rdy=1. If pending or rise -> LOAD and clear pending; else -> IDLE.
- Latency: rise sampled at edge t gives:
  - LOAD at cycle t+1;
  - I MACs at t+2..t+NTAPS+1;
  - i_vld at t+NTAPS+2;
  - q_vld at t+2*NTAPS+3;
  - demod_rdy at t+2*NTAPS+4.
  - NTAPS=8: demod_rdy at t+20. Minimum strobe period 2*NTAPS+4 cycles.
- Pending and overrun:
  - rise in any state other than IDLE or DONE: if pending=0, set pending; else set overrun and drop the strobe.
  - rise in DONE is consumed directly, same as pending.
  - ovr_clr clears overrun; if ovr_clr and a new overrun event coincide, set wins.
- Address arithmetic: unsigned ADDR_W bits, natural wrap. NTAPS=8, base=1, k=3 -> tap_addr=6.
- All outputs are decoded from registered state and counters. No combinational path from ADC_rdy to any output.
- Reset mid-operation: immediate return to IDLE. Partial MAC results are abandoned and no vld pulses are emitted.

Decomposition:
- Shared package iq_demod_pkg:
  - fsm enum sched_state_t;
  - default NTAPS constant;
  - ADDR_W function.
- One sub-module, rise_detect (ADC_rdy register plus rise output, async reset). Reusable by other strobe-driven blocks in the demodulator.

Test Plan:
- Reset, then single ADC_rdy rise at t (NTAPS=8):
  - wr_en at t+1 with wr_addr=0;
  - 8 MAC_I cycles: coef_addr 0..7, tap_addr 0,7,6,..,1;
  - i_vld at t+10, q_vld at t+19, demod_rdy at t+20;
  - busy low at t+21.
- ADC_rdy held high for 50 cycles -> exactly one demod_rdy pulse, overrun=0.
- Nine strobes spaced 20 cycles -> wr_addr sequence 0..7,0 (wrap); tap_addr for the 9th starts at 0 then 7; no overrun.
- Second rise at t+5 -> pending; after DONE at t+20, LOAD at t+21; second demod_rdy at t+40.
- Rises at t, t+5, t+8 -> overrun=1 at t+9 and exactly two demod_rdy pulses; ovr_clr pulse -> overrun=0.
- resetn low at t+12 (mid MAC_Q), then release -> all outputs 0, no q_vld/demod_rdy; the next strobe writes wr_addr=0.
